// File: rtl/exec_writeback_unit_if.sv
// Issue and write-back bundle between the register file read ports, the
// execute stage and the register file write port.
interface exec_writeback_unit_if #(
   parameter int WIDTH = 32,
   parameter int SEL_W = 3
);
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [2:0]       opcode;
   logic [SEL_W-1:0] dest;
   logic             valid_in;
   logic             ready_in;
   logic [WIDTH-1:0] wb_data;
   logic [SEL_W-1:0] wb_sel;
   logic             wb_we;
   logic             zero;
   logic             illegal_op;

   modport master (
      output op_a, op_b, opcode, dest, valid_in,
      input  ready_in, wb_data, wb_sel, wb_we, zero, illegal_op
   );

   modport slave (
      input  op_a, op_b, opcode, dest, valid_in,
      output ready_in, wb_data, wb_sel, wb_we, zero, illegal_op
   );
endinterface

// File: rtl/exec_writeback_unit.sv
// Execute/write-back stage: single-cycle ALU plus an iterative shift-add multiplier.
// Optional multiplier enabled by defining EXEC_MUL_EN; otherwise opcode 111 flags illegal_op.
module exec_writeback_unit #(
   parameter int WIDTH = 32,
   parameter int SEL_W = 3,
   parameter int SH_W  = 5
) (
   input logic                 clk,
   input logic                 reset,
   exec_writeback_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

   state_t           state;
   logic             accept;
   logic [WIDTH-1:0] alu_result;
   logic [WIDTH-1:0] wb_data_q;
   logic [SEL_W-1:0] wb_sel_q;
   logic             wb_we_q;
   logic             zero_q;
   logic             illegal_q;
   logic             ready_q;

`ifdef EXEC_MUL_EN
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [SH_W-1:0]  cnt;
   logic [SEL_W-1:0] dest_q;

   assign acc_next = mcand[0] ? (acc + mplier) : acc;
`endif

   assign accept = bus.valid_in && ready_q;

   // Single-cycle results are computed straight from the read ports so they
   // land in the write-back registers on the accepting edge.
   always_comb begin
      alu_result = '0;
      case (bus.opcode)
         3'b000: alu_result = bus.op_a + bus.op_b;
         3'b001: alu_result = bus.op_a - bus.op_b;
         3'b010: alu_result = bus.op_a & bus.op_b;
         3'b011: alu_result = bus.op_a | bus.op_b;
         3'b100: alu_result = bus.op_a ^ bus.op_b;
         3'b101: alu_result = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
         3'b110: alu_result = bus.op_a << bus.op_b[SH_W-1:0];
         default: alu_result = '0;
      endcase
   end

   // Control FSM with registered write-port outputs; ready is high only in IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wb_data_q <= '0;
         wb_sel_q  <= '0;
         wb_we_q   <= 1'b0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
         ready_q   <= 1'b1;
`ifdef EXEC_MUL_EN
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         dest_q    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  ready_q <= 1'b0;
                  if (bus.opcode == 3'b111) begin
`ifdef EXEC_MUL_EN
                     mcand  <= bus.op_a;
                     mplier <= bus.op_b;
                     acc    <= '0;
                     cnt    <= '0;
                     dest_q <= bus.dest;
                     state  <= MUL;
`else
                     illegal_q <= 1'b1;
                     state     <= WB;
`endif
                  end else begin
                     wb_data_q <= alu_result;
                     wb_sel_q  <= bus.dest;
                     zero_q    <= (alu_result == '0);
                     wb_we_q   <= 1'b1;
                     state     <= WB;
                  end
               end
            end
            MUL: begin
`ifdef EXEC_MUL_EN
               // Fixed WIDTH iterations, no early exit on a zero operand.
               acc    <= acc_next;
               mcand  <= mcand >> 1;
               mplier <= mplier << 1;
               cnt    <= cnt + 1'b1;
               if (cnt == SH_W'(WIDTH-1)) begin
                  wb_data_q <= acc_next;
                  wb_sel_q  <= dest_q;
                  zero_q    <= (acc_next == '0);
                  wb_we_q   <= 1'b1;
                  state     <= WB;
               end
`else
               state   <= IDLE;
               ready_q <= 1'b1;
`endif
            end
            WB: begin
               wb_we_q   <= 1'b0;
               illegal_q <= 1'b0;
               ready_q   <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready_in   = ready_q;
   assign bus.wb_data    = wb_data_q;
   assign bus.wb_sel     = wb_sel_q;
   assign bus.wb_we      = wb_we_q;
   assign bus.zero       = zero_q;
   assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_exec_writeback_unit.sv
// Directed-vector bench for exec_writeback_unit; covers the EXEC_MUL_EN build
// or the illegal-opcode build depending on the macro.
module tb_exec_writeback_unit;

   logic clk;
   logic reset;
   int   compared;
   int   mismatched;

   exec_writeback_unit_if #(.WIDTH(32), .SEL_W(3)) bus ();

   exec_writeback_unit #(.WIDTH(32), .SEL_W(3), .SH_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop so a stuck run still reports instead of hanging.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired before summary");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Presents one op for a single accepting edge, then drops valid.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [2:0] d);
      bus.opcode   = op;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.dest     = d;
      bus.valid_in = 1'b1;
      stepCycle();
      bus.valid_in = 1'b0;
      bus.op_a     = 32'hDEAD_BEEF;
      bus.op_b     = 32'hDEAD_BEEF;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_data"},  bus.wb_data, 32'h0);
      checkOutput({tag, "_sel"},   {29'd0, bus.wb_sel}, 32'h0);
      checkOutput({tag, "_we"},    {31'd0, bus.wb_we}, 32'h0);
      checkOutput({tag, "_zero"},  {31'd0, bus.zero}, 32'h0);
      checkOutput({tag, "_ill"},   {31'd0, bus.illegal_op}, 32'h0);
      checkOutput({tag, "_ready"}, {31'd0, bus.ready_in}, 32'h1);
   endtask

   task automatic checkWb(input string tag, input logic [31:0] data, input logic [2:0] sel,
                          input logic z);
      checkOutput({tag, "_we"},   {31'd0, bus.wb_we}, 32'h1);
      checkOutput({tag, "_data"}, bus.wb_data, data);
      checkOutput({tag, "_sel"},  {29'd0, bus.wb_sel}, {29'd0, sel});
      checkOutput({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, z});
      checkOutput({tag, "_rdy"},  {31'd0, bus.ready_in}, 32'h0);
      stepCycle();
      checkOutput({tag, "_we_off"}, {31'd0, bus.wb_we}, 32'h0);
      checkOutput({tag, "_rdy_on"}, {31'd0, bus.ready_in}, 32'h1);
      checkOutput({tag, "_hold"},   bus.wb_data, data);
   endtask

   initial begin
      int bad;
      compared     = 0;
      mismatched   = 0;
      reset        = 1'b1;
      bus.valid_in = 1'b0;
      bus.op_a     = '0;
      bus.op_b     = '0;
      bus.opcode   = '0;
      bus.dest     = '0;
      stepCycle();
      stepCycle();
      checkResetState("reset");
      reset = 1'b0;

      applyStimulus(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 3'd3);
      checkWb("add_wrap", 32'h0000_0001, 3'd3, 1'b0);

      applyStimulus(3'b001, 32'd5, 32'd5, 3'd7);
      checkWb("sub_zero", 32'h0, 3'd7, 1'b1);

      applyStimulus(3'b101, 32'hFFFF_FFFE, 32'd1, 3'd2);
      checkWb("slt_neg", 32'h1, 3'd2, 1'b0);

      applyStimulus(3'b101, 32'd1, 32'hFFFF_FFFE, 3'd4);
      checkWb("slt_pos", 32'h0, 3'd4, 1'b1);

      applyStimulus(3'b110, 32'h1, 32'h0000_0124, 3'd5);
      checkWb("shl", 32'h0000_0010, 3'd5, 1'b0);

      applyStimulus(3'b001, 32'd0, 32'd1, 3'd6);
      checkWb("sub_wrap", 32'hFFFF_FFFF, 3'd6, 1'b0);

      applyStimulus(3'b010, 32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd1);
      checkWb("and", 32'h00F0_000F, 3'd1, 1'b0);

      applyStimulus(3'b011, 32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd1);
      checkWb("or", 32'hFFF0_0FFF, 3'd1, 1'b0);

      applyStimulus(3'b100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd1);
      checkWb("xor", 32'hFF00_0FF0, 3'd1, 1'b0);

      // Valid held through the WB cycle: second op only accepted two edges later.
      bus.opcode = 3'b000; bus.op_a = 32'd1; bus.op_b = 32'd1; bus.dest = 3'd1;
      bus.valid_in = 1'b1;
      stepCycle();
      checkOutput("b2b_first", bus.wb_data, 32'd2);
      bus.opcode = 3'b100; bus.op_a = 32'd6; bus.op_b = 32'd3; bus.dest = 3'd2;
      stepCycle();
      checkOutput("b2b_gap_we", {31'd0, bus.wb_we}, 32'h0);
      checkOutput("b2b_gap_rdy", {31'd0, bus.ready_in}, 32'h1);
      stepCycle();
      bus.valid_in = 1'b0;
      checkWb("b2b_second", 32'd5, 3'd2, 1'b0);

`ifdef EXEC_MUL_EN
      bus.opcode = 3'b111; bus.op_a = 32'h0001_0003; bus.op_b = 32'h0002_0005; bus.dest = 3'd6;
      bus.valid_in = 1'b1;
      stepCycle();
      bus.opcode = 3'b000; bus.op_a = 32'd7; bus.op_b = 32'd7; bus.dest = 3'd1;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         if (bus.wb_we !== 1'b0 || bus.ready_in !== 1'b0 || bus.illegal_op !== 1'b0) bad++;
         stepCycle();
      end
      checkOutput("mul_busy", bad, 0);
      checkOutput("mul_we", {31'd0, bus.wb_we}, 32'h1);
      checkOutput("mul_data", bus.wb_data, 32'h000B_000F);
      checkOutput("mul_sel", {29'd0, bus.wb_sel}, 32'd6);
      checkOutput("mul_rdy", {31'd0, bus.ready_in}, 32'h0);
      stepCycle();
      bus.valid_in = 1'b0;
      checkOutput("mul_rdy_back", {31'd0, bus.ready_in}, 32'h1);
      checkOutput("mul_we_off", {31'd0, bus.wb_we}, 32'h0);

      applyStimulus(3'b111, 32'd9, 32'd9, 3'd4);
      for (int i = 0; i < 9; i++) stepCycle();
      reset = 1'b1;
      stepCycle();
      checkResetState("mul_abort");
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.wb_we !== 1'b0) bad++;
         stepCycle();
      end
      checkOutput("mul_abort_no_we", bad, 0);
`else
      applyStimulus(3'b111, 32'h0001_0003, 32'h0002_0005, 3'd6);
      checkOutput("ill_pulse", {31'd0, bus.illegal_op}, 32'h1);
      checkOutput("ill_we", {31'd0, bus.wb_we}, 32'h0);
      checkOutput("ill_data", bus.wb_data, 32'd5);
      checkOutput("ill_rdy", {31'd0, bus.ready_in}, 32'h0);
      stepCycle();
      checkOutput("ill_pulse_off", {31'd0, bus.illegal_op}, 32'h0);
      checkOutput("ill_rdy_back", {31'd0, bus.ready_in}, 32'h1);
      checkOutput("ill_data_hold", bus.wb_data, 32'd5);
`endif

      applyStimulus(3'b000, 32'd2, 32'd3, 3'd0);
      checkWb("add_dest0", 32'd5, 3'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
